// File: rtl/adc_capture_ctrl.sv
// ADC sample capture into an AXI4-Stream master with frame framing, a test-pattern
// source, continuous (real-time) re-framing and a sticky sample-drop flag.
module adc_capture_ctrl (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [31:0] dsize,
  input  logic        cr_start,
  input  logic        cr_test,
  input  logic        cr_rt,
  input  logic [15:0] adc_data,
  input  logic        adc_valid,
  output logic [15:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] len_q;
  logic        test_q;
  logic [31:0] sample_cnt_q;
  logic [15:0] test_cnt_q;
  logic [15:0] tdata_q;
  logic        tvalid_q;
  logic        tlast_q;
  logic        done_q;
  logic        overflow_q;

  logic        handshake;
  logic        out_free;
  logic        start_ok;
  logic        accept;
  logic        drop;
  logic        frame_end;
  logic        last_hs;
  logic [31:0] cnt_next;
  logic [15:0] sample_sel;

  // The ADC cannot be stalled: a sample either fits in the output register
  // (empty, or emptying this cycle) or it is lost.
  assign handshake  = tvalid_q & M_AXIS_TREADY;
  assign out_free   = ~tvalid_q | M_AXIS_TREADY;
  assign start_ok   = (state_q == ST_IDLE) & cr_start & (dsize != 32'd0);
  assign accept     = (state_q == ST_RUN) & adc_valid & out_free;
  assign drop       = (state_q == ST_RUN) & adc_valid & ~out_free;
  assign cnt_next   = sample_cnt_q + 32'd1;
  assign frame_end  = accept & (cnt_next == len_q);
  assign last_hs    = (state_q == ST_DRAIN) & handshake;
  assign sample_sel = test_q ? test_cnt_q : adc_data;

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok)  state_d = ST_RUN;
      ST_RUN:   if (frame_end) state_d = ST_DRAIN;
      ST_DRAIN: if (last_hs)   state_d = cr_rt ? ST_RUN : ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments and the asynchronous active-low
  // reset, so a mid-frame reset clears the stream outputs without waiting for a clock.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= ST_IDLE;
      len_q        <= 32'd0;
      test_q       <= 1'b0;
      sample_cnt_q <= 32'd0;
      test_cnt_q   <= 16'd0;
      tdata_q      <= 16'd0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_hs & ~cr_rt;

      if (accept) begin
        tdata_q  <= sample_sel;
        tvalid_q <= 1'b1;
        tlast_q  <= frame_end;
      end else if (handshake) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end

      // Frame length and source are frozen at start; later register writes wait.
      if (start_ok) begin
        len_q        <= dsize;
        test_q       <= cr_test;
        sample_cnt_q <= 32'd0;
        test_cnt_q   <= 16'd0;
      end else if (accept) begin
        sample_cnt_q <= cnt_next;
        test_cnt_q   <= test_cnt_q + 16'd1;
      end else if (last_hs && cr_rt) begin
        sample_cnt_q <= 32'd0;
        test_cnt_q   <= 16'd0;
      end

      if (start_ok) begin
        overflow_q <= 1'b0;
      end else if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign overflow      = overflow_q;

endmodule
